// File: rtl/pp_gen_if.sv
// Bus bundle for pp_gen_pipe: upstream image/weight beat, downstream partial-product beat.
// The master modport is the side that feeds beats and drains results.
interface pp_gen_if #(
    parameter int LANES  = 4,
    parameter int IEXP_W = 4,
    parameter int IMAN_W = 3,
    parameter int WEXP_W = 3
);
    localparam int IMG_W  = 1 + IEXP_W + IMAN_W;
    localparam int WGT_W  = 1 + WEXP_W;
    localparam int PP_W   = IMAN_W + 2;
    localparam int EXP_OW = ((IEXP_W > WEXP_W) ? IEXP_W : WEXP_W) + 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*IMG_W-1:0]    image;
    logic [LANES*WGT_W-1:0]    weight;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*PP_W-1:0]     signed_pp;
    logic [LANES*EXP_OW-1:0]   exp;
    logic [LANES-1:0]          zero_mask;
    logic [EXP_OW-1:0]         max_exp;

    modport master (
        output in_valid, image, weight, out_ready,
        input  in_ready, out_valid, signed_pp, exp, zero_mask, max_exp
    );

    modport slave (
        input  in_valid, image, weight, out_ready,
        output in_ready, out_valid, signed_pp, exp, zero_mask, max_exp
    );
endinterface

// File: rtl/pp_gen_pipe.sv
// Two-stage multi-lane partial-product generator for the SD4 log-domain MAC, with a saturating
// zero-lane counter. Define PPG_MAXEXP_EN to build the per-beat max non-zero exponent output.
module pp_gen_pipe #(
    parameter int LANES  = 4,
    parameter int IEXP_W = 4,
    parameter int IMAN_W = 3,
    parameter int WEXP_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    pp_gen_if.slave          bus,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] zero_cnt
);
    localparam int IMG_W  = 1 + IEXP_W + IMAN_W;
    localparam int WGT_W  = 1 + WEXP_W;
    localparam int PP_W   = IMAN_W + 2;
    localparam int EXP_OW = ((IEXP_W > WEXP_W) ? IEXP_W : WEXP_W) + 1;
    localparam int POP_W  = $clog2(LANES + 1);
    localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    logic                              s2_adv_s;
    logic                              s1_adv_s;
    logic                              fire_s;

    logic [LANES-1:0]                  dec_zero_s;
    logic [LANES-1:0]                  dec_sign_s;
    logic [LANES-1:0][IMAN_W-1:0]      dec_man_s;
    logic [LANES-1:0][EXP_OW-1:0]      dec_exp_s;

    logic                              s1_valid_r;
    logic [LANES-1:0]                  s1_zero_r;
    logic [LANES-1:0]                  s1_sign_r;
    logic [LANES-1:0][IMAN_W-1:0]      s1_man_r;
    logic [LANES-1:0][EXP_OW-1:0]      s1_exp_r;
    logic [LANES-1:0][PP_W-1:0]        s1_pp_s;

    logic                              out_valid_r;
    logic [LANES-1:0][PP_W-1:0]        signed_pp_r;
    logic [LANES-1:0][EXP_OW-1:0]      exp_r;
    logic [LANES-1:0]                  zero_mask_r;

    logic [SUM_W-1:0]                  cnt_base_s;
    logic [SUM_W-1:0]                  cnt_sum_s;
    logic [CNT_W-1:0]                  cnt_next_s;
    logic [CNT_W-1:0]                  zero_cnt_r;

    // A stage may load when it is empty or its contents leave this cycle.
    assign s2_adv_s     = ~out_valid_r | bus.out_ready;
    assign s1_adv_s     = ~s1_valid_r | s2_adv_s;
    assign fire_s       = out_valid_r & bus.out_ready;
    assign bus.in_ready = s1_adv_s;

    // Per-lane operand decode; a zero lane carries a zero exponent from S1 onward.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            dec_zero_s[i] = (bus.image[i*IMG_W +: (IEXP_W + IMAN_W)] == '0) ||
                            (&bus.weight[i*WGT_W +: WEXP_W]);
            dec_sign_s[i] = bus.image[i*IMG_W + IMG_W - 1] ^ bus.weight[i*WGT_W + WGT_W - 1];
            dec_man_s[i]  = bus.image[i*IMG_W +: IMAN_W];
            if (dec_zero_s[i]) begin
                dec_exp_s[i] = '0;
            end else begin
                dec_exp_s[i] = EXP_OW'(bus.image[i*IMG_W + IMAN_W +: IEXP_W]) +
                               EXP_OW'(bus.weight[i*WGT_W +: WEXP_W]);
            end
        end
    end

    // S1 register: decoded lane fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_zero_r  <= '0;
            s1_sign_r  <= '0;
            s1_man_r   <= '0;
            s1_exp_r   <= '0;
        end else if (s1_adv_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_zero_r <= dec_zero_s;
                s1_sign_r <= dec_sign_s;
                s1_man_r  <= dec_man_s;
                s1_exp_r  <= dec_exp_s;
            end
        end
    end

    // Assemble the signed partial product {sign,1,man}, forced to zero for zero lanes.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (s1_zero_r[i]) begin
                s1_pp_s[i] = '0;
            end else begin
                s1_pp_s[i] = {s1_sign_r[i], 1'b1, s1_man_r[i]};
            end
        end
    end

    // S2 output register; holds its data while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            signed_pp_r <= '0;
            exp_r       <= '0;
            zero_mask_r <= '0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                signed_pp_r <= s1_pp_s;
                exp_r       <= s1_exp_r;
                zero_mask_r <= s1_zero_r;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.signed_pp = signed_pp_r;
    assign bus.exp       = exp_r;
    assign bus.zero_mask = zero_mask_r;

`ifdef PPG_MAXEXP_EN
    logic [EXP_OW-1:0] s1_max_s;
    logic [EXP_OW-1:0] max_exp_r;

    // Largest exponent among non-zero lanes of the beat held in S1.
    always_comb begin
        s1_max_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!s1_zero_r[i] && (s1_exp_r[i] > s1_max_s)) begin
                s1_max_s = s1_exp_r[i];
            end else begin
                s1_max_s = s1_max_s;
            end
        end
    end

    // Max exponent travels with the S2 beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_exp_r <= '0;
        end else if (s2_adv_s && s1_valid_r) begin
            max_exp_r <= s1_max_s;
        end
    end

    assign bus.max_exp = max_exp_r;
`else
    assign bus.max_exp = '0;
`endif

    // Next zero count: clear takes effect before the delivered beat's zeros are added.
    always_comb begin
        if (cnt_clr) begin
            cnt_base_s = '0;
        end else begin
            cnt_base_s = SUM_W'(zero_cnt_r);
        end
        if (fire_s) begin
            cnt_sum_s = cnt_base_s + SUM_W'(popcount(zero_mask_r));
        end else begin
            cnt_sum_s = cnt_base_s;
        end
        if (|cnt_sum_s[SUM_W-1:CNT_W]) begin
            cnt_next_s = '1;
        end else begin
            cnt_next_s = cnt_sum_s[CNT_W-1:0];
        end
    end

    // Zero-lane counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt_r <= '0;
        end else begin
            zero_cnt_r <= cnt_next_s;
        end
    end

    assign zero_cnt = zero_cnt_r;
endmodule

// File: tb/tb_pp_gen_pipe.sv
// Scoreboard bench for pp_gen_pipe: driver pushes model results on accept, a monitor pops and
// compares on each delivered beat and also tracks in_ready, output stability and zero_cnt.
module tb_pp_gen_pipe;
    localparam int CNT_W = 3;
    localparam int CMAX  = 7;

    typedef struct {
        logic [19:0] pp;
        logic [19:0] ex;
        logic [3:0]  zm;
        logic [4:0]  mx;
        int          acc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             cnt_clr;
    logic [CNT_W-1:0] zero_cnt;

    pp_gen_if #(.LANES(4), .IEXP_W(4), .IMAN_W(3), .WEXP_W(3)) bus ();

    pp_gen_pipe #(.LANES(4), .IEXP_W(4), .IMAN_W(3), .WEXP_W(3), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .cnt_clr  (cnt_clr),
        .zero_cnt (zero_cnt)
    );

    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_stall = -100;
    int          model_cnt = 0;
    bit          prev_hold = 1'b0;
    logic [19:0] prev_pp;
    logic [19:0] prev_ex;
    logic [3:0]  prev_zm;
    logic [4:0]  prev_mx;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: lane value = sign * 16 + 8 + mantissa, exponent = iexp + wexp, both 0 for zero lanes.
    function automatic exp_t model(input logic [31:0] img, input logic [15:0] wgt, input int acc);
        exp_t e;
        int   mx;
        mx    = 0;
        e.pp  = '0;
        e.ex  = '0;
        e.zm  = '0;
        e.acc = acc;
        for (int l = 0; l < 4; l++) begin
            int isg, iex, man, wsg, wex, ppv, ev;
            bit zero;
            isg  = int'(img[l*8+7]);
            iex  = int'(img[l*8+3 +: 4]);
            man  = int'(img[l*8 +: 3]);
            wsg  = int'(wgt[l*4+3]);
            wex  = int'(wgt[l*4 +: 3]);
            zero = ((iex == 0) && (man == 0)) || (wex == 7);
            ppv  = zero ? 0 : ((isg ^ wsg) * 16 + 8 + man);
            ev   = zero ? 0 : (iex + wex);
            e.pp[l*5 +: 5] = ppv[4:0];
            e.ex[l*5 +: 5] = ev[4:0];
            e.zm[l]        = zero;
            if (!zero && ev > mx) mx = ev;
        end
`ifdef PPG_MAXEXP_EN
        e.mx = mx[4:0];
`else
        e.mx = 5'd0;
`endif
        return e;
    endfunction

    function automatic int zcount(input logic [3:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) n += int'(m[i]);
        return n;
    endfunction

    task automatic rand_beat(output logic [31:0] img, output logic [15:0] wgt);
        for (int l = 0; l < 4; l++) begin
            img[l*8 +: 8] = 8'($urandom);
            wgt[l*4 +: 4] = 4'($urandom);
            if ($urandom_range(0, 7) == 0) img[l*8 +: 7] = 7'd0;
        end
    endtask

    // One cycle: drive at the falling edge, then check in_ready against pipe occupancy.
    task automatic step(input logic v, input logic [31:0] img, input logic [15:0] wgt,
                        input logic ordy, input logic clr, output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.image     = img;
        bus.weight    = wgt;
        bus.out_ready = ordy;
        cnt_clr       = clr;
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'((sb_q.size() < 2) || ordy));
        acc = v && bus.in_ready;
        if (acc) sb_q.push_back(model(img, wgt, cyc + 1));
    endtask

    task automatic idle(input int n, input logic ordy);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 16'd0, ordy, 1'b0, a);
    endtask

    // Monitor: samples mid-cycle, after the driver has settled this cycle's inputs.
    always @(negedge clk) begin
        exp_t e;
        int   pc;
        #2;
        if (!rst) begin
            pc = 0;
            chk("zero_cnt", 32'(zero_cnt), 32'(model_cnt));
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_pp", 32'(bus.signed_pp), 32'(prev_pp));
                chk("hold_exp", 32'(bus.exp), 32'(prev_ex));
                chk("hold_zmask", 32'(bus.zero_mask), 32'(prev_zm));
                chk("hold_maxexp", 32'(bus.max_exp), 32'(prev_mx));
            end
            if (!bus.out_ready) last_stall = cyc + 1;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("signed_pp", 32'(bus.signed_pp), 32'(e.pp));
                    chk("exp", 32'(bus.exp), 32'(e.ex));
                    chk("zero_mask", 32'(bus.zero_mask), 32'(e.zm));
                    chk("max_exp", 32'(bus.max_exp), 32'(e.mx));
                    if (last_stall < e.acc) chk("latency", 32'(cyc + 1 - e.acc), 32'd2);
                    pc = zcount(e.zm);
                end
            end
            model_cnt = (cnt_clr ? 0 : model_cnt) + pc;
            if (model_cnt > CMAX) model_cnt = CMAX;
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_pp   = bus.signed_pp;
            prev_ex   = bus.exp;
            prev_zm   = bus.zero_mask;
            prev_mx   = bus.max_exp;
        end
    end

    initial begin
        logic [31:0] img;
        logic [15:0] wgt;
        logic [31:0] imgs[8];
        logic [15:0] wgts[8];
        logic        a;
        int          k;
        int          idx;

        rst = 1'b1;
        cnt_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.image = '0;
        bus.weight = '0;
        #13;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pp", 32'(bus.signed_pp), 32'd0);
        chk("rst_exp", 32'(bus.exp), 32'd0);
        chk("rst_zmask", 32'(bus.zero_mask), 32'd0);
        chk("rst_maxexp", 32'(bus.max_exp), 32'd0);
        chk("rst_zero_cnt", 32'(zero_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed lane decode, then zero-lane forms (weight code 111, negative-zero image).
        step(1'b1, {8'h35, 8'h49, 8'h2C, 8'b0_1010_101}, {4'h2, 4'h1, 4'h5, 4'b1_010}, 1'b1, 1'b0, a);
        step(1'b1, {8'h35, 8'h49, 8'h80, 8'h5A}, {4'h2, 4'h1, 4'hB, 4'b0_111}, 1'b1, 1'b0, a);
        // Max exponent case: lane exps 12, 3, zero lane, 21; then an all-zero beat.
        step(1'b1, {8'b1_1111_011, 8'h00, 8'b0_0011_001, 8'b0_1010_110},
                   {4'b0_110, 4'h3, 4'b1_000, 4'b0_010}, 1'b1, 1'b0, a);
        step(1'b1, {8'h80, 8'h00, 8'h21, 8'h47}, {4'h1, 4'h2, 4'hF, 4'h7}, 1'b1, 1'b0, a);
        idle(3, 1'b1);

        // Back-to-back beats with a three-cycle downstream stall.
        for (int i = 0; i < 8; i++) begin
            rand_beat(img, wgt);
            imgs[i] = img;
            wgts[i] = wgt;
        end
        k = 0;
        idx = 0;
        while (idx < 8 && k < 40) begin
            step(1'b1, imgs[idx], wgts[idx], !(k >= 3 && k <= 5), 1'b0, a);
            if (a) idx++;
            k++;
        end
        chk("b2b_accepted", 32'(idx), 32'd8);
        idle(3, 1'b1);

        // Counter saturation with three-zero beats, then clear coinciding with a one-zero delivery.
        step(1'b0, 32'd0, 16'd0, 1'b1, 1'b1, a);
        for (int i = 0; i < 3; i++)
            step(1'b1, {8'h21, 8'h33, 8'h44, 8'h55}, {4'h1, 4'h7, 4'hF, 4'h7}, 1'b1, 1'b0, a);
        idle(3, 1'b1);
        step(1'b1, {8'h21, 8'h33, 8'h44, 8'h55}, {4'h1, 4'h2, 4'h3, 4'h7}, 1'b1, 1'b0, a);
        idle(1, 1'b1);
        step(1'b0, 32'd0, 16'd0, 1'b1, 1'b1, a);
        idle(2, 1'b1);

        // Reset while both stages hold a beat, then a beat straight after.
        rand_beat(img, wgt);
        step(1'b1, img, wgt, 1'b0, 1'b0, a);
        rand_beat(img, wgt);
        step(1'b1, img, wgt, 1'b0, 1'b0, a);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_zero_cnt", 32'(zero_cnt), 32'd0);
        sb_q.delete();
        model_cnt = 0;
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rand_beat(img, wgt);
        step(1'b1, img, wgt, 1'b1, 1'b0, a);
        chk("post_rst_accept", 32'(a), 32'd1);
        idle(3, 1'b1);

        // Randomized traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            rand_beat(img, wgt);
            step(($urandom_range(0, 3) != 0), img, wgt, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0), a);
        end

        k = 0;
        while (sb_q.size() != 0 && k < 20) begin
            idle(1, 1'b1);
            k++;
        end
        idle(1, 1'b1);
        chk("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
